// File: rtl/irq_src_filter.sv
// rtl/irq_src_filter.sv - per-source interrupt synchroniser, glitch filter, pending latch and enable mask
module irq_src_filter #(
    parameter int NUM_SRC  = 3,
    parameter int FILT_LEN = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_SRC-1:0] raw_irq_i,
    input  logic               cfg_we_i,
    input  logic               cfg_re_i,
    input  logic [1:0]         cfg_addr_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic [31:0]        cfg_rdata_o,
    output logic [NUM_SRC-1:0] irq_o
);

    localparam logic [7:0] CNT_MAX = 8'(FILT_LEN - 1);

    logic [NUM_SRC-1:0] s1_q, s1_d;
    logic [NUM_SRC-1:0] s2_q, s2_d;
    logic [NUM_SRC-1:0] filt_q, filt_d;
    logic [7:0]         cnt_q [NUM_SRC];
    logic [7:0]         cnt_d [NUM_SRC];
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] irq_q, irq_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] wdata_src;
    logic [NUM_SRC-1:0] w1c_mask;
    logic [NUM_SRC-1:0] force_mask;
    logic [NUM_SRC-1:0] rd_sel;

    logic unused_wdata;
    assign unused_wdata = ^cfg_wdata_i[31:NUM_SRC];

    always_comb begin
        s1_d   = raw_irq_i;
        s2_d   = s1_q;
        filt_d = filt_q;
        rise   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                filt_d[i] = s2_q[i];
                cnt_d[i]  = '0;
                rise[i]   = s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end

        wdata_src  = cfg_wdata_i[NUM_SRC-1:0];
        enable_d   = (cfg_we_i && cfg_addr_i == 2'd0) ? wdata_src : enable_q;
        w1c_mask   = (cfg_we_i && cfg_addr_i == 2'd1) ? wdata_src : '0;
        force_mask = (cfg_we_i && cfg_addr_i == 2'd3) ? wdata_src : '0;
        // Sets are ORed in after the clear so a same-cycle set always wins.
        pending_d  = (pending_q & ~w1c_mask) | rise | force_mask;
        irq_d      = pending_q & enable_q;

        case (cfg_addr_i)
            2'd0:    rd_sel = enable_q;
            2'd1:    rd_sel = pending_q;
            2'd2:    rd_sel = filt_q;
            default: rd_sel = '0;
        endcase
        rdata_d = cfg_re_i ? 32'(rd_sel) : rdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_q      <= '0;
            s2_q      <= '0;
            filt_q    <= '0;
            enable_q  <= '0;
            pending_q <= '0;
            irq_q     <= '0;
            rdata_q   <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            filt_q    <= filt_d;
            enable_q  <= enable_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cfg_rdata_o = rdata_q;
    assign irq_o       = irq_q;

endmodule

// File: doc/irq_src_filter.md
Name: irq_src_filter

Overview:
Per-peripheral interrupt source conditioner that sits directly upstream of the interrupt controller. It takes raw interrupt lines from the pkt SRAM, CAN and UART blocks, which may be asynchronous or glitchy. Each line is synchronised, glitch-filtered and latched into a pending bit, then gated by an enable mask. The result is a clean level irq_o per source; the interrupt controller edge-detects it. Software configures and clears sources through a small word-addressed config port.

Parameters:
NUM_SRC, 3, number of interrupt sources (1..16); matches `NUM_PERI at instantiation.
FILT_LEN, 4, consecutive stable cycles required before the filtered level changes (1..255).

Ports:
clk_i  in  1  system clock.
rst_n_i  in  1  reset: synchronous, active-low.
raw_irq_i  in  NUM_SRC  raw peripheral interrupt levels; may be asynchronous.
cfg_we_i  in  1  config write strobe.
cfg_re_i  in  1  config read strobe.
cfg_addr_i  in  2  register select.
cfg_wdata_i  in  32  write data.
cfg_rdata_o  out  32  registered read data.
irq_o  out  NUM_SRC  conditioned level interrupt to the interrupt controller (pending & enable), registered.

Behaviour:
- Reset (rst_n_i low at a clk_i edge) clears every flop: sync stages, filter counters, filtered levels, ENABLE, PENDING, irq_o=0, cfg_rdata_o=0.
- Reset is honoured mid-operation: any in-progress count is discarded.
- A source still held high after reset is treated as a new rising event: pending sets FILT_LEN+2 edges after reset deasserts.
- Sync: two flops per source, s1 then s2, no other logic between them.
- Filter, per source: a counter of width 8 and a filtered level filt.
  - If s2==filt, the counter is cleared.
  - Else if counter==FILT_LEN-1: filt<=s2 and counter<=0.
  - Else the counter increments.
  - Any s2 pulse shorter than FILT_LEN cycles never changes filt.
- Pending: on the edge where filt goes 0->1, PENDING[i]<=1, independent of ENABLE. A filt 1->0 transition does not clear pending.
- Latency: raw rises before edge 1 -> s2 high at edge 2 -> filt and PENDING set at edge 2+FILT_LEN -> irq_o high at edge 3+FILT_LEN.
- irq_o <= PENDING & ENABLE, registered.
- Register map (word index cfg_addr_i):
  - 0 ENABLE: rw, bits [NUM_SRC-1:0].
  - 1 PENDING: read; write-1-to-clear.
  - 2 STATUS: read-only filt levels; writes ignored.
  - 3 FORCE: write-1 sets PENDING (software-triggered irq); reads 0.
  - Unimplemented bits read 0 and ignore writes.
- Simultaneous events in one cycle:
  - Hardware set (filt rise) or FORCE set together with W1C on the same bit: set wins, bit stays 1.
  - Clearing ENABLE drops irq_o on the next edge; pending is retained. Re-enabling re-raises irq_o, which the controller sees as a fresh edge.
- Read: when cfg_re_i=1, cfg_rdata_o captures the addressed register's current (pre-update) value at the edge; otherwise it holds. Latency is 1 cycle.
- cfg_we_i and cfg_re_i together are legal: the read returns the pre-write value.
- No wrap-around is possible: the counter is bounded by FILT_LEN-1.

Test Plan:
1. Reset, FILT_LEN=4; ENABLE=3'b111; raw_irq_i[0] rises before edge 1 and stays high -> PENDING[0]=1 at edge 6, irq_o[0]=1 at edge 7, STATUS reads 3'b001.
2. raw_irq_i[1] pulses high for 3 cycles (s2 high 3 cycles) -> STATUS[1] stays 0, PENDING stays 0, irq_o[1] never rises. Repeat with 4 cycles -> PENDING[1]=1.
3. With PENDING=3'b011, write PENDING 0x2 -> PENDING=3'b001 next cycle, irq_o[1] falls, irq_o[0] stays 1. Read addr 1 -> cfg_rdata_o=0x1 one cycle later.
4. Same cycle as filt[2] rising, write PENDING 0x4 -> PENDING[2]=1 (set wins). FORCE write 0x1 with ENABLE=0 -> PENDING[0]=1, irq_o[0]=0; then ENABLE=1 -> irq_o[0]=1 next edge.
5. Assert rst_n_i for one edge while counter=2 and PENDING=3'b111 -> all registers 0, irq_o=0. With raw_irq_i[0] held high, PENDING[0] re-sets FILT_LEN+2 edges after release.
6. Read and write addr 0 in the same cycle (old ENABLE 0x5, write 0x2) -> cfg_rdata_o=0x5, ENABLE=0x2. Read addr 3 -> 0.
